ysyx_23060077_riscv_regfile_sb: RTL and testbench
=================================================

// Module: ysyx_23060077_riscv_regfile_sb
// PURPOSE
//  Consumer side of the decode stage: takes the decoded {rs1,rs2,rd,rd_wen} issue request, returns operand
//  data, and tracks in-flight destination registers in a scoreboard. Stalls issue on RAW/WAW hazards.
//  Commits register writes from the write-back stage.
//  Sits between ID and EX; the write-back port is driven by the WB stage.
// PARAMETERS
//  XLEN     32  register data width
//  NR_REG   32  number of architectural registers (x0 hardwired to zero)
//  AW        5  register address width, log2(NR_REG)
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst          in   1     asynchronous, active-high reset
//  issue_valid  in   1     ID presents a decoded instruction
//  issue_ready  out  1     no hazard; issue accepted when valid&ready
//  issue_rs1    in   AW    source 1 index (0 = unused)
//  issue_rs2    in   AW    source 2 index (0 = unused)
//  issue_rd     in   AW    destination index
//  issue_rd_wen in   1     instruction will write rd
//  rs1_data     out  XLEN  operand 1, combinational, bypassed
//  rs2_data     out  XLEN  operand 2, combinational, bypassed
//  wb_valid     in   1     write-back commit this cycle
//  wb_rd        in   AW    write-back destination
//  wb_data      in   XLEN  write-back value
//  flush        in   1     pipeline flush: clear all busy bits
//  sb_busy      out  NR_REG  registered busy vector (bit0 always 0)
//  sb_err       out  1     registered 1-cycle pulse: wb to non-busy reg
// BEHAVIOUR
//  Reset (async): all regs 0, busy 0, sb_err 0. issue_ready is combinational, so it is 1 after reset.
//  Read: rsN_data = 0 if rsN==0; wb_data if wb_valid & wb_rd==rsN & wb_rd!=0; else regs[rsN].
//  Hazard: src_hz(rsN) = rsN!=0 & busy[rsN] & ~(wb_valid & wb_rd==rsN). WAW hz = issue_rd_wen & issue_rd!=0
//    & busy[rd] & ~(wb_valid & wb_rd==rd). issue_ready = ~flush & ~src_hz(rs1) & ~src_hz(rs2) & ~waw_hz.
//  Issue fire (valid&ready&rd_wen&rd!=0): busy[rd] <= 1 next edge. No effect on regs.
//  Write-back: wb_valid & wb_rd!=0 -> regs[wb_rd] <= wb_data and busy[wb_rd] <= 0.
//    wb to x0 is ignored.
//  Same-cycle set and clear of one index (issue rd == wb_rd): set wins, busy stays 1.
//  sb_err <= wb_valid & wb_rd!=0 & ~busy[wb_rd]. The register is still written.
//  flush: busy <= 0 for all indices. issue_ready forced 0 that cycle.
//    A wb in the same cycle still writes regs.
//  Latency: operand read 0 cycles; write visible via bypass in the same cycle, via regs next cycle.
//  issue_valid low: no state change from the issue port. Outputs remain valid (don't-care by ID).
//  Reset mid-operation clears busy and regs immediately; pending WB results are lost by design.
// STRUCTURE
//  riscv_define.vh: XLEN, NR_REG, AW, and the x0 index constant REG_ZERO.
//  Sub-module ysyx_23060077_riscv_scoreboard holds:
//    - the busy vector
//    - set/clear/flush logic
//    - hazard compare, sb_err
//  The top holds:
//    - the register array
//    - the bypass muxes
//    - the issue_ready combine
// TESTING
//  1 reset, read rs1=5 rs2=0 -> data 0/0; issue_ready=1; sb_busy=0.
//  2 wb x3=0xDEADBEEF; same cycle read rs1=3 -> rs1_data=0xDEADBEEF (bypass); next cycle from regs.
//  3 issue rd=7 wen; next instr rs2=7 -> issue_ready=0 until wb x7=0x12, which releases it in the
//    same cycle; rs2_data=0x12.
//  4 issue rd=9 with same-cycle wb x9 -> sb_busy[9]=1 after edge; wb x0=0xFFFF -> x0 still reads 0.
//  5 wb x4 while busy[4]=0 -> sb_err=1 for one cycle; regs[4] updated.
//  6 busy {5,6}, assert flush -> issue_ready=0 that cycle; sb_busy=0 next; assert rst mid-stream
//    -> all regs read 0 asynchronously.

Source files
------------

// File: rtl/ysyx_23060077_riscv_regfile_sb_pkg.sv
// Shared widths, index types and the operand bypass helper for the
// register file / scoreboard slice.
package ysyx_23060077_riscv_regfile_sb_pkg;

  localparam int XLEN   = 32;
  localparam int NR_REG = 32;
  localparam int AW     = $clog2(NR_REG);

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] xlen_t;

  localparam reg_idx_t REG_ZERO = '0;

  // x0 reads zero; a same-cycle commit to the requested index wins over the array.
  function automatic xlen_t read_operand(
    input reg_idx_t idx,
    input logic     wb_valid,
    input reg_idx_t wb_rd,
    input xlen_t    wb_data,
    input xlen_t    reg_val
  );
    if (idx == REG_ZERO) begin
      return '0;
    end
    if (wb_valid && (wb_rd == idx)) begin
      return wb_data;
    end
    return reg_val;
  endfunction

endpackage

// File: rtl/ysyx_23060077_riscv_regfile_sb_scoreboard.sv
// Busy-bit scoreboard: tracks in-flight destinations, reports RAW/WAW hazards
// and flags write-backs to registers that were never marked busy.
module ysyx_23060077_riscv_scoreboard
  import ysyx_23060077_riscv_regfile_sb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_fire,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  input  logic [AW-1:0]     rd,
  input  logic              rd_wen,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic              flush,
  output logic              src1_hz,
  output logic              src2_hz,
  output logic              waw_hz,
  output logic [NR_REG-1:0] busy,
  output logic              sb_err
);

  logic              wb_commit;
  logic              set_en;
  logic [NR_REG-1:0] busy_next;

  assign wb_commit = wb_valid && (wb_rd != REG_ZERO);
  assign set_en    = issue_fire && rd_wen && (rd != REG_ZERO);

  // A commit landing this cycle already resolves the hazard on that index.
  assign src1_hz = (rs1 != REG_ZERO) && busy[rs1] && !(wb_valid && (wb_rd == rs1));
  assign src2_hz = (rs2 != REG_ZERO) && busy[rs2] && !(wb_valid && (wb_rd == rs2));
  assign waw_hz  = rd_wen && (rd != REG_ZERO) && busy[rd] && !(wb_valid && (wb_rd == rd));

  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (wb_commit) begin
      busy_next[wb_rd] = 1'b0;
    end
    // Applied after the clear so a same-index issue keeps the register busy.
    if (set_en) begin
      busy_next[rd] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
    busy_next[REG_ZERO] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      busy   <= busy_next;
      sb_err <= wb_commit && !busy[wb_rd];
    end
  end

endmodule

// File: rtl/ysyx_23060077_riscv_regfile_sb.sv
// Register file between ID and EX: bypassed operand reads, write-back commit,
// and issue gating from the scoreboard hazards.
module ysyx_23060077_riscv_regfile_sb
  import ysyx_23060077_riscv_regfile_sb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [AW-1:0]     issue_rs1,
  input  logic [AW-1:0]     issue_rs2,
  input  logic [AW-1:0]     issue_rd,
  input  logic              issue_rd_wen,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic [NR_REG-1:0] sb_busy,
  output logic              sb_err
);

  logic [XLEN-1:0] regs [NR_REG];
  logic            src1_hz;
  logic            src2_hz;
  logic            waw_hz;
  logic            issue_fire;

  assign issue_ready = !flush && !src1_hz && !src2_hz && !waw_hz;
  assign issue_fire  = issue_valid && issue_ready;

  ysyx_23060077_riscv_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .issue_fire(issue_fire),
    .rs1       (issue_rs1),
    .rs2       (issue_rs2),
    .rd        (issue_rd),
    .rd_wen    (issue_rd_wen),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .flush     (flush),
    .src1_hz   (src1_hz),
    .src2_hz   (src2_hz),
    .waw_hz    (waw_hz),
    .busy      (sb_busy),
    .sb_err    (sb_err)
  );

  // NOTE: the array is reset deliberately; a mid-run reset must read back all zeros at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_REG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid && (wb_rd != REG_ZERO)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign rs1_data = read_operand(issue_rs1, wb_valid, wb_rd, wb_data, regs[issue_rs1]);
  assign rs2_data = read_operand(issue_rs2, wb_valid, wb_rd, wb_data, regs[issue_rs2]);

endmodule

// File: tb/tb_ysyx_23060077_riscv_regfile_sb.sv
// Directed bench for the register file / scoreboard: reset, bypass, RAW/WAW
// stalls, set-wins, sb_err, flush and asynchronous reset.
module tb_ysyx_23060077_riscv_regfile_sb;

  localparam int XLEN   = 32;
  localparam int NR_REG = 32;
  localparam int AW     = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic              issue_ready;
  logic [AW-1:0]     issue_rs1;
  logic [AW-1:0]     issue_rs2;
  logic [AW-1:0]     issue_rd;
  logic              issue_rd_wen;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              wb_valid;
  logic [AW-1:0]     wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic [NR_REG-1:0] sb_busy;
  logic              sb_err;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ysyx_23060077_riscv_regfile_sb dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .issue_rd_wen(issue_rd_wen),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flush       (flush),
    .sb_busy     (sb_busy),
    .sb_err      (sb_err)
  );

  task automatic set_issue(input logic v, input int rs1, input int rs2, input int rd, input logic wen);
    issue_valid  = v;
    issue_rs1    = AW'(rs1);
    issue_rs2    = AW'(rs2);
    issue_rd     = AW'(rd);
    issue_rd_wen = wen;
  endtask

  task automatic set_wb(input logic v, input int rd, input logic [XLEN-1:0] data);
    wb_valid = v;
    wb_rd    = AW'(rd);
    wb_data  = data;
  endtask

  // Advance past the next rising edge; inputs are then driven and outputs sampled 1-2 time units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    flush = 1'b0;
    set_issue(1'b0, 5, 0, 0, 1'b0);
    set_wb(1'b0, 0, '0);
    step();
    step();
    rst = 1'b0;
    #1;
    tests++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      failed++;
      $display("FAIL reset_read rs1=%h rs2=%h expected 0/0", rs1_data, rs2_data);
    end
    tests++;
    if (issue_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_ready got %b expected 1", issue_ready);
    end
    tests++;
    if (sb_busy !== '0 || sb_err !== 1'b0) begin
      failed++;
      $display("FAIL reset_sb busy=%h err=%b expected 0/0", sb_busy, sb_err);
    end
  endtask

  task automatic test_bypass();
    step();
    set_issue(1'b0, 3, 0, 0, 1'b0);
    set_wb(1'b1, 3, 32'hDEADBEEF);
    #1;
    tests++;
    if (rs1_data !== 32'hDEADBEEF) begin
      failed++;
      $display("FAIL bypass_same_cycle got %h expected deadbeef", rs1_data);
    end
    step();
    set_wb(1'b0, 0, '0);
    #1;
    tests++;
    if (rs1_data !== 32'hDEADBEEF) begin
      failed++;
      $display("FAIL bypass_from_regs got %h expected deadbeef", rs1_data);
    end
    step();
  endtask

  task automatic test_raw_stall();
    set_issue(1'b1, 0, 0, 7, 1'b1);
    #1;
    tests++;
    if (issue_ready !== 1'b1) begin
      failed++;
      $display("FAIL raw_first_issue ready=%b expected 1", issue_ready);
    end
    step();
    set_issue(1'b1, 0, 7, 8, 1'b1);
    #1;
    tests++;
    if (issue_ready !== 1'b0 || sb_busy !== 32'h0000_0080) begin
      failed++;
      $display("FAIL raw_stall ready=%b busy=%h expected 0/00000080", issue_ready, sb_busy);
    end
    step();
    #1;
    tests++;
    if (issue_ready !== 1'b0) begin
      failed++;
      $display("FAIL raw_stall_hold ready=%b expected 0", issue_ready);
    end
    set_wb(1'b1, 7, 32'h12);
    #1;
    tests++;
    if (issue_ready !== 1'b1 || rs2_data !== 32'h12) begin
      failed++;
      $display("FAIL raw_release ready=%b rs2=%h expected 1/00000012", issue_ready, rs2_data);
    end
    step();
    set_issue(1'b0, 0, 0, 0, 1'b0);
    set_wb(1'b0, 0, '0);
    #1;
    tests++;
    if (sb_busy !== 32'h0000_0100 || sb_err !== 1'b0) begin
      failed++;
      $display("FAIL raw_after busy=%h err=%b expected 00000100/0", sb_busy, sb_err);
    end
    set_wb(1'b1, 8, 32'h88);
    step();
    set_wb(1'b0, 0, '0);
    #1;
    tests++;
    if (sb_busy !== '0 || sb_err !== 1'b0) begin
      failed++;
      $display("FAIL raw_drain busy=%h err=%b expected 0/0", sb_busy, sb_err);
    end
  endtask

  task automatic test_set_wins();
    set_issue(1'b1, 0, 0, 9, 1'b1);
    set_wb(1'b1, 9, 32'h99);
    step();
    set_issue(1'b0, 0, 0, 0, 1'b0);
    set_wb(1'b1, 0, 32'hFFFF);
    #1;
    tests++;
    if (sb_busy !== 32'h0000_0200) begin
      failed++;
      $display("FAIL set_wins busy=%h expected 00000200", sb_busy);
    end
    tests++;
    if (rs1_data !== 32'h0) begin
      failed++;
      $display("FAIL x0_bypass got %h expected 0", rs1_data);
    end
    step();
    set_wb(1'b0, 0, '0);
    #1;
    tests++;
    if (rs1_data !== 32'h0 || sb_err !== 1'b0 || sb_busy !== 32'h0000_0200) begin
      failed++;
      $display("FAIL x0_ignored rs1=%h err=%b busy=%h expected 0/0/00000200", rs1_data, sb_err, sb_busy);
    end
    set_wb(1'b1, 9, 32'h99);
    step();
    set_wb(1'b0, 0, '0);
    step();
  endtask

  task automatic test_sb_err();
    set_issue(1'b0, 4, 0, 0, 1'b0);
    set_wb(1'b1, 4, 32'h44);
    step();
    set_wb(1'b0, 0, '0);
    #1;
    tests++;
    if (sb_err !== 1'b1 || rs1_data !== 32'h44) begin
      failed++;
      $display("FAIL sb_err_pulse err=%b rs1=%h expected 1/00000044", sb_err, rs1_data);
    end
    step();
    tests++;
    if (sb_err !== 1'b0) begin
      failed++;
      $display("FAIL sb_err_one_cycle err=%b expected 0", sb_err);
    end
  endtask

  task automatic test_flush_reset();
    set_issue(1'b1, 0, 0, 5, 1'b1);
    step();
    set_issue(1'b1, 0, 0, 6, 1'b1);
    step();
    set_issue(1'b1, 0, 0, 5, 1'b1);
    #1;
    tests++;
    if (sb_busy !== 32'h0000_0060 || issue_ready !== 1'b0) begin
      failed++;
      $display("FAIL waw_stall busy=%h ready=%b expected 00000060/0", sb_busy, issue_ready);
    end
    set_issue(1'b1, 0, 0, 10, 1'b1);
    flush = 1'b1;
    set_wb(1'b1, 5, 32'h55);
    #1;
    tests++;
    if (issue_ready !== 1'b0) begin
      failed++;
      $display("FAIL flush_ready got %b expected 0", issue_ready);
    end
    step();
    flush = 1'b0;
    set_wb(1'b0, 0, '0);
    set_issue(1'b0, 5, 4, 0, 1'b0);
    #1;
    tests++;
    if (sb_busy !== '0 || rs1_data !== 32'h55) begin
      failed++;
      $display("FAIL flush_clear busy=%h rs1=%h expected 0/00000055", sb_busy, rs1_data);
    end
    set_issue(1'b0, 3, 4, 0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || sb_busy !== '0) begin
      failed++;
      $display("FAIL async_reset rs1=%h rs2=%h busy=%h expected 0/0/0", rs1_data, rs2_data, sb_busy);
    end
    step();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_raw_stall();
    test_set_wins();
    test_sb_err();
    test_flush_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
